i2c_target_regs: RTL and testbench
==================================

// Module: i2c_target_regs
// PURPOSE
//  I2C target (slave) that answers the I2C master in the Nios system.
//  Presents a small byte register bank at one 7-bit bus address, using pointer-then-data addressing with auto-increment.
//  Register contents are exported flat to fabric logic (config/status for the pebble sensors).
//  Pins are open-drain style: the *_oe outputs pull the line low, and the *_in inputs read the line.
// PARAMETERS
//  I2C_ADDR     7'h42  7-bit target address matched after START
//  AW           3      register index width; bank holds 2**AW bytes
//  SYNC_STAGES  2      input synchronizer depth on SCL/SDA (>=2)
// PORTS
//  clk_clk        in   1            system clock; must be >= 20x SCL frequency
//  reset_reset_n  in   1            asynchronous active-low reset
//  i2c_sda_in     in   1            SDA line level
//  i2c_scl_in     in   1            SCL line level
//  i2c_sda_oe     out  1            1 = pull SDA low
//  i2c_scl_oe     out  1            1 = pull SCL low; tied 0, no clock stretching
//  regs_export    out  8*2**AW      register bank; byte i at [8i+7:8i]
//  wr_strobe      out  1            one-cycle pulse when a register byte is written
//  wr_index       out  AW           index of the byte written; valid with wr_strobe
//  busy           out  1            1 from an address-matched ACK until STOP or next START
// BEHAVIOUR
//  Reset:
//   - Synchronizer flops reset to 1 (idle bus).
//   - sda_oe=0, scl_oe=0, regs=0, ptr=0, wr_strobe=0, wr_index=0, busy=0, state IDLE.
//   - Reset mid-transfer releases SDA immediately (async).
//  Sampling and events:
//   - SCL and SDA pass through SYNC_STAGES flops. Edge and event detection uses the synced value vs. its one-cycle delay.
//   - START = SDA fall while SCL high. STOP = SDA rise while SCL high.
//   - START or STOP has priority over any bit event in the same cycle.
//   - START in any state (repeated START included): state=ADDR, bitcnt=0, SDA released.
//   - STOP in any state: state=IDLE, SDA released, busy=0.
//  Bits:
//   - Received bits are sampled on the synced SCL rising edge, MSB first.
//   - The target changes SDA only on the cycle after a synced SCL falling edge.
//  States:
//   - IDLE: ignore the bus until START.
//   - ADDR: shift 8 bits.
//     - On the 8th rise, if addr[7:1]==I2C_ADDR, latch rw=bit0; on the next fall go to ACK_A and set sda_oe=1.
//     - On mismatch go to IDLE (wait for START/STOP).
//   - ACK_A: hold sda_oe=1 through the ACK clock. busy=1. On the ACK-ending fall:
//     - rw=0: release SDA, go to PTR.
//     - rw=1: go to RD and drive bit7 of regs[ptr] (sda_oe = ~bit).
//   - PTR: shift 8 bits. On the 8th rise, ptr = byte[AW-1:0] (upper bits ignored). Then ACK_P (like ACK_A), then WR.
//   - WR: shift 8 bits.
//     - On the 8th rise, regs[ptr] = byte, wr_strobe=1 for one clk_clk, wr_index=ptr, ptr=ptr+1 mod 2**AW.
//     - Then ACK_W (like ACK_A), then back to WR.
//   - RD: drive the next bit on each fall.
//     - After the 8th bit's fall, release SDA and go to MACK.
//     - The outgoing byte is captured into the shift register at load time, so fabric-side changes mid-byte are not seen.
//   - MACK: sample SDA on the rise.
//     - Low (ACK): ptr=ptr+1 mod 2**AW; on the fall load regs[ptr] and go to RD.
//     - High (NACK): go to IDLE with SDA released.
//  Pointer:
//   - ptr persists across transactions.
//   - A read without a preceding pointer write starts at the current ptr.
//   - Wrap from 2**AW-1 to 0 silently, on both read and write.
//  Other rules:
//   - Only ACK phases and read data ever assert sda_oe. sda_oe is never asserted while the synced SCL is high except when held over from the preceding low phase.
//   - Latency: sda_oe changes SYNC_STAGES+1 clk_clk cycles after the SCL pin falls. This gives SDA hold time.
// TESTING
//  1. Reset, then write [START 0x84 A 0x02 A 0xAA A 0x55 A STOP].
//     -> byte2=0xAA, byte3=0x55; two wr_strobe pulses with wr_index 2,3; ptr=4; ACK low on all 4 ACK slots.
//  2. After test 1: [START 0x84 A 0x02 A Sr 0x85 A rd rd(NACK) STOP].
//     -> reads 0xAA then 0x55; SDA released after the NACK; busy=0 after STOP.
//  3. Write [START 0x84 0x07 0x11 0x22 STOP] with AW=3.
//     -> byte7=0x11, byte0=0x22 (wrap); ptr=1.
//  4. Address [START 0x90 ...] (addr 0x48).
//     -> no ACK, sda_oe stays 0 for the whole frame, regs unchanged, busy stays 0.
//  5. Assert reset_reset_n=0 while driving the ACK bit.
//     -> sda_oe=0 the same cycle; after release, a fresh write to 0x42 succeeds.
//  6. STOP mid-byte during WR after 4 bits.
//     -> no register write, no wr_strobe, state IDLE; the next START+0x84 ACKs normally.

Source files
------------

// File: rtl/i2c_target_regs.sv
// I2C target exposing a 2**AW byte register bank at one 7-bit address.
// Pointer-then-data addressing with auto-increment; open-drain pin style.
module i2c_target_regs #(
  parameter logic [6:0]  I2C_ADDR    = 7'h42,
  parameter int unsigned AW          = 3,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                    clk_clk,
  input  logic                    reset_reset_n,
  input  logic                    i2c_sda_in,
  input  logic                    i2c_scl_in,
  output logic                    i2c_sda_oe,
  output logic                    i2c_scl_oe,
  output logic [8*(2**AW)-1:0]    regs_export,
  output logic                    wr_strobe,
  output logic [AW-1:0]           wr_index,
  output logic                    busy
);

  localparam int unsigned NREGS  = 2**AW;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ACK_A,
    S_PTR,
    S_ACK_P,
    S_WR,
    S_ACK_W,
    S_RD,
    S_MACK
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_d;
  logic                   sda_d;
  logic                   scl_s;
  logic                   sda_s;
  logic                   scl_rise;
  logic                   scl_fall;
  logic                   start_ev;
  logic                   stop_ev;
  logic [7:0]             rx_sr;
  logic [7:0]             rx_byte;
  logic [7:0]             tx_sr;
  logic [3:0]             bitcnt;
  logic                   rw;
  logic                   mack_ack;
  logic [AW-1:0]          ptr;
  logic [7:0]             regs [NREGS];

  assign i2c_scl_oe = 1'b0;

  // Synchronizers reset to 1 so an idle bus produces no spurious edges.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], i2c_scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], i2c_sda_in};
      scl_d    <= scl_sync[SYNC_STAGES-1];
      sda_d    <= sda_sync[SYNC_STAGES-1];
    end
  end

  always_comb begin
    scl_s    = scl_sync[SYNC_STAGES-1];
    sda_s    = sda_sync[SYNC_STAGES-1];
    scl_rise = scl_s & ~scl_d;
    scl_fall = ~scl_s & scl_d;
    start_ev = scl_s & scl_d & sda_d & ~sda_s;
    stop_ev  = scl_s & scl_d & ~sda_d & sda_s;
    rx_byte  = {rx_sr[6:0], sda_s};
  end

  always_comb begin
    regs_export = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      regs_export[8*i +: 8] = regs[i];
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state      <= S_IDLE;
      i2c_sda_oe <= 1'b0;
      wr_strobe  <= 1'b0;
      wr_index   <= '0;
      busy       <= 1'b0;
      rx_sr      <= '0;
      tx_sr      <= '0;
      bitcnt     <= '0;
      rw         <= 1'b0;
      mack_ack   <= 1'b0;
      ptr        <= '0;
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      wr_strobe <= 1'b0;
      if (start_ev) begin
        state      <= S_ADDR;
        bitcnt     <= '0;
        i2c_sda_oe <= 1'b0;
        busy       <= 1'b0;
      end else if (stop_ev) begin
        state      <= S_IDLE;
        i2c_sda_oe <= 1'b0;
        busy       <= 1'b0;
      end else begin
        case (state)
          S_IDLE: ;
          // The three receive states share bit shifting; they differ only in
          // what the completed byte does and which ACK state follows.
          S_ADDR, S_PTR, S_WR: begin
            if (scl_rise && bitcnt != 4'd8) begin
              rx_sr  <= rx_byte;
              bitcnt <= bitcnt + 4'd1;
              if (bitcnt == 4'd7) begin
                case (state)
                  S_ADDR: begin
                    if (rx_byte[7:1] == I2C_ADDR) rw <= rx_byte[0];
                    else                          state <= S_IDLE;
                  end
                  S_PTR: ptr <= rx_byte[AW-1:0];
                  default: begin
                    regs[ptr] <= rx_byte;
                    wr_strobe <= 1'b1;
                    wr_index  <= ptr;
                    ptr       <= ptr + PTR_ONE;
                  end
                endcase
              end
            end else if (scl_fall && bitcnt == 4'd8) begin
              i2c_sda_oe <= 1'b1;
              if (state == S_ADDR) begin
                state <= S_ACK_A;
                busy  <= 1'b1;
              end else if (state == S_PTR) begin
                state <= S_ACK_P;
              end else begin
                state <= S_ACK_W;
              end
            end
          end
          S_ACK_A, S_ACK_P, S_ACK_W: begin
            if (scl_fall) begin
              bitcnt <= '0;
              if (state == S_ACK_A && rw) begin
                tx_sr      <= regs[ptr];
                i2c_sda_oe <= ~regs[ptr][7];
                bitcnt     <= 4'd1;
                state      <= S_RD;
              end else begin
                i2c_sda_oe <= 1'b0;
                state      <= (state == S_ACK_A) ? S_PTR : S_WR;
              end
            end
          end
          S_RD: begin
            if (scl_fall) begin
              if (bitcnt == 4'd8) begin
                i2c_sda_oe <= 1'b0;
                mack_ack   <= 1'b0;
                state      <= S_MACK;
              end else begin
                tx_sr      <= {tx_sr[6:0], 1'b0};
                i2c_sda_oe <= ~tx_sr[6];
                bitcnt     <= bitcnt + 4'd1;
              end
            end
          end
          S_MACK: begin
            if (scl_rise) begin
              if (!sda_s) begin
                ptr      <= ptr + PTR_ONE;
                mack_ack <= 1'b1;
              end else begin
                state <= S_IDLE;
              end
            end else if (scl_fall && mack_ack) begin
              tx_sr      <= regs[ptr];
              i2c_sda_oe <= ~regs[ptr][7];
              bitcnt     <= 4'd1;
              state      <= S_RD;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-banged I2C master with a scoreboard of
// expected ACK/read bytes and expected register writes.
module tb_i2c_target_regs;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sda_m = 1'b1;
  logic        scl_m = 1'b1;
  logic        sda_line;
  logic        sda_oe;
  logic        scl_oe;
  logic [63:0] regs_export;
  logic        wr_strobe;
  logic [2:0]  wr_index;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string      tag;
    logic [7:0] val;
  } exp_t;
  typedef struct {
    logic [2:0] idx;
    logic [7:0] val;
  } wr_t;

  exp_t       exp_q[$];
  logic [7:0] obs_q[$];
  wr_t        wr_q[$];

  logic watch     = 1'b0;
  logic watch_hit = 1'b0;

  always #5 clk = ~clk;

  assign sda_line = sda_m & ~sda_oe;

  i2c_target_regs #(
    .I2C_ADDR    (7'h42),
    .AW          (3),
    .SYNC_STAGES (2)
  ) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .i2c_sda_in    (sda_line),
    .i2c_scl_in    (scl_m),
    .i2c_sda_oe    (sda_oe),
    .i2c_scl_oe    (scl_oe),
    .regs_export   (regs_export),
    .wr_strobe     (wr_strobe),
    .wr_index      (wr_index),
    .busy          (busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  always @(posedge clk) if (watch && (sda_oe || busy)) watch_hit = 1'b1;

  // Monitor: pops expectations whenever the DUT presents a write or the bus
  // master has captured a DUT-driven bit/byte.
  initial begin
    wr_t  w;
    exp_t e;
    logic [7:0] o;
    forever begin
      @(negedge clk);
      if (wr_strobe) begin
        if (wr_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_wr_strobe actual_index=%0d required=none", wr_index);
        end else begin
          w = wr_q.pop_front();
          check("wr_index", 64'(wr_index), 64'(w.idx));
          check("wr_data", 64'(regs_export[8*w.idx +: 8]), 64'(w.val));
        end
      end
      while (obs_q.size() > 0) begin
        o = obs_q.pop_front();
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_observation actual=%h required=none", o);
        end else begin
          e = exp_q.pop_front();
          check(e.tag, 64'(o), 64'(e.val));
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic wt();
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wt();
    scl_m = 1'b1; wt();
    sda_m = 1'b0; wt();
    scl_m = 1'b0; wt();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wt();
    scl_m = 1'b1; wt();
    sda_m = 1'b1; wt();
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;    wt();
    scl_m = 1'b1; wt(); wt();
    scl_m = 1'b0; wt();
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wt();
    scl_m = 1'b1; wt();
    b = sda_line; wt();
    scl_m = 1'b0; wt();
  endtask

  task automatic write_byte(input logic [7:0] b, input logic exp_ack, input string tag);
    logic a;
    exp_q.push_back('{tag, {7'b0, exp_ack}});
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    read_bit(a);
    obs_q.push_back({7'b0, a});
  endtask

  task automatic read_byte(input logic [7:0] exp_val, input logic nack, input string tag);
    logic [7:0] d;
    logic       b;
    exp_q.push_back('{tag, exp_val});
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    obs_q.push_back(d);
    send_bit(nack);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_sda_oe", 64'(sda_oe), 64'd0);
    check("reset_scl_oe", 64'(scl_oe), 64'd0);
    check("reset_regs", regs_export, 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_wr_strobe", 64'(wr_strobe), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    wt();

    // Test 1: pointer write then two data bytes
    i2c_start();
    write_byte(8'h84, 1'b0, "t1_addr_ack");
    check("t1_busy_after_ack", 64'(busy), 64'd1);
    write_byte(8'h02, 1'b0, "t1_ptr_ack");
    wr_q.push_back('{3'd2, 8'hAA});
    write_byte(8'hAA, 1'b0, "t1_d0_ack");
    wr_q.push_back('{3'd3, 8'h55});
    write_byte(8'h55, 1'b0, "t1_d1_ack");
    i2c_stop();
    wt();
    check("t1_regs", regs_export, 64'h00000000_55AA0000);
    check("t1_busy_after_stop", 64'(busy), 64'd0);

    // Test 2: pointer write, repeated START, read two bytes
    i2c_start();
    write_byte(8'h84, 1'b0, "t2_addr_ack");
    write_byte(8'h02, 1'b0, "t2_ptr_ack");
    i2c_start();
    write_byte(8'h85, 1'b0, "t2_raddr_ack");
    read_byte(8'hAA, 1'b0, "t2_rd0");
    check("t2_busy_in_read", 64'(busy), 64'd1);
    read_byte(8'h55, 1'b1, "t2_rd1");
    check("t2_sda_released_after_nack", 64'(sda_oe), 64'd0);
    i2c_stop();
    wt();
    check("t2_busy_after_stop", 64'(busy), 64'd0);

    // Test 3: write across the wrap point
    i2c_start();
    write_byte(8'h84, 1'b0, "t3_addr_ack");
    write_byte(8'h07, 1'b0, "t3_ptr_ack");
    wr_q.push_back('{3'd7, 8'h11});
    write_byte(8'h11, 1'b0, "t3_d0_ack");
    wr_q.push_back('{3'd0, 8'h22});
    write_byte(8'h22, 1'b0, "t3_d1_ack");
    i2c_stop();
    wt();
    check("t3_regs", regs_export, 64'h11000000_55AA0022);
    // read without pointer write starts at ptr=1
    i2c_start();
    write_byte(8'h85, 1'b0, "t3_raddr_ack");
    read_byte(8'h00, 1'b0, "t3_rd_ptr1");
    read_byte(8'hAA, 1'b1, "t3_rd_ptr2");
    i2c_stop();
    wt();

    // Test 4: foreign address
    watch_hit = 1'b0;
    watch     = 1'b1;
    i2c_start();
    write_byte(8'h90, 1'b1, "t4_addr_nack");
    write_byte(8'h00, 1'b1, "t4_data_nack");
    i2c_stop();
    wt();
    watch = 1'b0;
    check("t4_no_oe_no_busy", 64'(watch_hit), 64'd0);
    check("t4_regs_unchanged", regs_export, 64'h11000000_55AA0022);

    // Test 5: reset while the target drives ACK
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(1'(8'h84 >> i));
    sda_m = 1'b1; wt();
    scl_m = 1'b1; wt();
    check("t5_ack_driven", 64'(sda_oe), 64'd1);
    rst_n = 1'b0;
    #1;
    check("t5_async_release", 64'(sda_oe), 64'd0);
    check("t5_regs_cleared", regs_export, 64'd0);
    wt();
    @(negedge clk) rst_n = 1'b1;
    wt();
    i2c_start();
    write_byte(8'h84, 1'b0, "t5_addr_ack");
    write_byte(8'h00, 1'b0, "t5_ptr_ack");
    wr_q.push_back('{3'd0, 8'h5A});
    write_byte(8'h5A, 1'b0, "t5_d0_ack");
    i2c_stop();
    wt();
    check("t5_regs", regs_export, 64'h00000000_0000005A);

    // Test 6: STOP after 4 data bits
    i2c_start();
    write_byte(8'h84, 1'b0, "t6_addr_ack");
    write_byte(8'h03, 1'b0, "t6_ptr_ack");
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    i2c_stop();
    wt();
    check("t6_busy_after_stop", 64'(busy), 64'd0);
    check("t6_regs_unchanged", regs_export, 64'h00000000_0000005A);
    i2c_start();
    write_byte(8'h84, 1'b0, "t6_next_addr_ack");
    i2c_stop();
    wt();

    repeat (5) @(posedge clk);
    #1;
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    check("wr_q_drained", 64'(wr_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
